dtfag_tf_lane_loader: RTL and testbench
=======================================

// Module: dtfag_tf_lane_loader
// PURPOSE
//  - Producer side of the DTFAG radix-16 twiddle path: accepts twiddle factors serially, one word per cycle, and assembles them into groups of 16 lanes.
//  - Presents each complete group in parallel as the R16 lane bus plus Mul_sel, which feed the multiplier-input mux.
//  - Double-buffered: one bank fills while the other is presented, so there is no stall at steady state.
// PARAMETERS
//  D_WIDTH   64   twiddle word width; equals `D_width
//  LANES     16   lanes per group; must be a power of 2; lane counter width is $clog2(LANES)
//  CNT_W     16   width of the completed-group counter
// PORTS
//  clk        in   1                 clock, rising edge
//  rst_n      in   1                 async active-low reset
//  flush      in   1                 sync clear: empty both banks, zero the lane counter
//  tf_data    in   D_WIDTH           serial twiddle word
//  tf_valid   in   1                 tf_data valid
//  tf_ready   out  1                 loader can accept tf_data
//  grp_en     in   1                 sampled with lane-0 word; 1 -> group is applied (Mul_sel=1), 0 -> group is zeroed (Mul_sel=0)
//  r16_bus    out  LANES*D_WIDTH     lane k at [k*D_WIDTH +: D_WIDTH]; maps to R16_in0..R16_in15
//  Mul_sel    out  2                 2'd1 = apply lanes; 2'd0 = multiplier inputs forced to 0
//  out_valid  out  1                 r16_bus/Mul_sel hold a complete group
//  out_ready  in   1                 downstream consumes the group
//  grp_cnt    out  CNT_W             number of groups consumed; wraps modulo 2^CNT_W
// BEHAVIOUR
//  - Reset (rst_n=0, async): both bank data regs = 0; full[1:0] = 0; wr_bank = rd_bank = 0; lane_cnt = 0; grp_en regs = 0; grp_cnt = 0.
//    Resulting outputs: out_valid=0, Mul_sel=2'd0, r16_bus=0, tf_ready=1.
//  - Write side:
//    - tf_ready = ~full[wr_bank] (combinational).
//    - Accept = tf_valid & tf_ready: write tf_data to bank[wr_bank] lane lane_cnt; lane_cnt++.
//    - At lane_cnt==0, also latch grp_en into sel[wr_bank].
//    - When lane LANES-1 is accepted: lane_cnt wraps to 0, full[wr_bank] <= 1, wr_bank toggles.
//  - Read side:
//    - out_valid = full[rd_bank]; r16_bus = bank[rd_bank] at all times.
//    - Mul_sel = out_valid ? {1'b0, sel[rd_bank]} : 2'd0. Mul_sel never reads 1 without a full group.
//    - Consume = out_valid & out_ready: full[rd_bank] <= 0, rd_bank toggles, grp_cnt++.
//  - Latency: lane LANES-1 accepted in cycle t -> out_valid=1 in cycle t+1 (if that bank is next to read).
//  - Throughput: one group per LANES cycles sustained with out_ready held 1.
//  - Simultaneous events:
//    - Fill-complete on wr_bank and consume on rd_bank in the same cycle (different banks): both take effect.
//    - Same bank: impossible by construction, since a full bank has tf_ready=0.
//  - Full: both banks full -> tf_ready=0, lane_cnt holds; tf_data is ignored.
//  - Empty: out_valid=0; out_ready is ignored; grp_cnt is unchanged.
//  - flush (sync, priority over all accepts and consumes):
//    - full = 0, lane_cnt = 0, wr_bank = rd_bank = 0.
//    - Bank data and grp_cnt are retained.
//    - Takes effect next cycle; a partially filled group is discarded.
//  - Reset mid-group: all state returns to reset values immediately; no partial group survives.
//  - Stability: while out_valid=1 and out_ready=0, r16_bus and Mul_sel are held stable.
// STRUCTURE
//  - Shared package dtfag_pkg: D_WIDTH, LANES, MUL_SEL_APPLY=2'd1, MUL_SEL_ZERO=2'd0, and the lane-slice helper function.
//  - One sub-module: dtfag_tf_bank. It holds a single LANES x D_WIDTH register bank with a lane write enable, a sel bit, and a full flag.
//    The top instantiates it twice and adds the wr_bank/rd_bank pointers, the lane counter and grp_cnt.
//  - No FSM enum is needed; the state is {full[1:0], wr_bank, rd_bank, lane_cnt}.
// TESTING
//  1. Reset: rst_n low -> out_valid=0, Mul_sel=0, tf_ready=1, r16_bus=0; rst_n deasserted asynchronously mid-cycle -> same values hold.
//  2. Single group: out_ready=0, grp_en=1, tf_data=k+1 for k=0..15 -> out_valid=1 the cycle after word 16; lane k = k+1; Mul_sel=2'd1.
//     Then out_ready=1 -> grp_cnt=1 and out_valid drops.
//  3. Backpressure: out_ready=0, 32 words streamed -> tf_ready=0 after word 32; word 33 is not accepted.
//     out_ready=1 for one cycle -> group 1 is released, tf_ready=1, r16_bus shows group 2 (values 17..32).
//  4. Streaming: out_ready=1, 64 words continuous -> 4 groups in order, no tf_ready gap, grp_cnt=4.
//  5. Zero group: grp_en=0 on the lane-0 word (grp_en=1 on later words) -> Mul_sel=2'd0 for that group; the next grp_en=1 group gives Mul_sel=2'd1.
//  6. Flush/reset mid-group: 7 words, then flush=1 -> lane_cnt=0; the next 16 words form a clean group with lane 0 = first post-flush word.
//     Repeat with rst_n pulsed low -> grp_cnt=0.

Source files
------------

// File: rtl/dtfag_pkg.sv
// Shared constants and helpers for the DTFAG radix-16 twiddle path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dtfag_pkg;

    localparam int D_WIDTH = 64;
    localparam int LANES   = 16;

    localparam logic [1:0] MUL_SEL_APPLY = 2'd1;
    localparam logic [1:0] MUL_SEL_ZERO  = 2'd0;

    // Extract lane k from a flat lane bus (lane k lives at [k*D_WIDTH +: D_WIDTH]).
    function automatic logic [D_WIDTH-1:0] lane_of(input logic [LANES*D_WIDTH-1:0] bus,
                                                   input int unsigned               k);
        return bus[k*D_WIDTH +: D_WIDTH];
    endfunction

endpackage

// File: rtl/dtfag_tf_bank.sv
// One LANES x D_WIDTH twiddle bank with a per-lane write, a group-enable bit and a full flag.
// Latency: a lane write is visible on data_o the cycle after wr_en_i.
// Backpressure: none internally; the owner must not write while full_o is set.
module dtfag_tf_bank #(
    parameter int D_WIDTH = 64,
    parameter int LANES   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       wr_en_i,
    input  logic [$clog2(LANES)-1:0]   wr_lane_i,
    input  logic [D_WIDTH-1:0]         wr_dat_i,
    input  logic                       grp_en_i,
    input  logic                       set_full_i,
    input  logic                       clr_full_i,
    output logic [LANES*D_WIDTH-1:0]   data_o,
    output logic                       sel_o,
    output logic                       full_o
);

    logic [D_WIDTH-1:0] data_q [LANES];
    logic               sel_q;
    logic               full_q;
    logic               full_d;

    // Lane storage: only the addressed lane is written; flush leaves the contents alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LANES; k++) begin
                data_q[k] <= '0;
            end
        end else if (wr_en_i) begin
            data_q[wr_lane_i] <= wr_dat_i;
        end
    end

    // The group enable travels with the lane-0 word and applies to the whole group.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= 1'b0;
        end else if (wr_en_i && (wr_lane_i == '0)) begin
            sel_q <= grp_en_i;
        end
    end

    // Full flag: flush empties the bank; set and clear never target the same bank together.
    always_comb begin
        full_d = full_q;
        if (flush_i) begin
            full_d = 1'b0;
        end else if (set_full_i) begin
            full_d = 1'b1;
        end else if (clr_full_i) begin
            full_d = 1'b0;
        end
    end

    // Full flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
        end else begin
            full_q <= full_d;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_flat
        assign data_o[k*D_WIDTH +: D_WIDTH] = data_q[k];
    end

    assign sel_o  = sel_q;
    assign full_o = full_q;

endmodule

// File: rtl/dtfag_tf_lane_loader.sv
// Serial-to-parallel twiddle loader: packs one word per cycle into double-buffered LANES-wide groups.
// Latency: last lane accepted in cycle t -> group valid in cycle t+1 when its bank is next to read.
// Backpressure: tf_ready drops only when the bank being filled is still full (both banks waiting).
module dtfag_tf_lane_loader
    import dtfag_pkg::*;
#(
    parameter int D_WIDTH = dtfag_pkg::D_WIDTH,
    parameter int LANES   = dtfag_pkg::LANES,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [D_WIDTH-1:0]         tf_data,
    input  logic                       tf_valid,
    output logic                       tf_ready,
    input  logic                       grp_en,
    output logic [LANES*D_WIDTH-1:0]   r16_bus,
    output logic [1:0]                 Mul_sel,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CNT_W-1:0]           grp_cnt
);

    localparam int LW = $clog2(LANES);

    logic [LW-1:0]            lane_cnt_q, lane_cnt_d;
    logic                     wr_bank_q, wr_bank_d;
    logic                     rd_bank_q, rd_bank_d;
    logic [CNT_W-1:0]         grp_cnt_q, grp_cnt_d;

    logic [1:0]               full;
    logic [1:0]               sel;
    logic [LANES*D_WIDTH-1:0] bank_dat [2];

    logic                     accept;
    logic                     last_lane;
    logic                     consume;

    // Flush wins over any accept or consume in the same cycle.
    assign tf_ready  = ~full[wr_bank_q];
    assign accept    = tf_valid & tf_ready & ~flush;
    assign last_lane = accept & (lane_cnt_q == LW'(LANES - 1));
    assign out_valid = full[rd_bank_q];
    assign consume   = out_valid & out_ready & ~flush;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        dtfag_tf_bank #(
            .D_WIDTH (D_WIDTH),
            .LANES   (LANES)
        ) u_bank (
            .clk        (clk),
            .rst_n      (rst_n),
            .flush_i    (flush),
            .wr_en_i    (accept    && (wr_bank_q == 1'(b))),
            .wr_lane_i  (lane_cnt_q),
            .wr_dat_i   (tf_data),
            .grp_en_i   (grp_en),
            .set_full_i (last_lane && (wr_bank_q == 1'(b))),
            .clr_full_i (consume   && (rd_bank_q == 1'(b))),
            .data_o     (bank_dat[b]),
            .sel_o      (sel[b]),
            .full_o     (full[b])
        );
    end

    // Pointer, lane counter and consumed-group counter next state.
    always_comb begin
        lane_cnt_d = lane_cnt_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        grp_cnt_d  = grp_cnt_q;
        if (flush) begin
            lane_cnt_d = '0;
            wr_bank_d  = 1'b0;
            rd_bank_d  = 1'b0;
        end else begin
            if (accept) begin
                lane_cnt_d = lane_cnt_q + 1'b1;
            end
            if (last_lane) begin
                lane_cnt_d = '0;
                wr_bank_d  = ~wr_bank_q;
            end
            if (consume) begin
                rd_bank_d = ~rd_bank_q;
                grp_cnt_d = grp_cnt_q + 1'b1;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_cnt_q <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            grp_cnt_q  <= '0;
        end else begin
            lane_cnt_q <= lane_cnt_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            grp_cnt_q  <= grp_cnt_d;
        end
    end

    // Read side: the presented bank is always visible; Mul_sel only applies with a full group.
    always_comb begin
        r16_bus = bank_dat[rd_bank_q];
        Mul_sel = MUL_SEL_ZERO;
        if (out_valid && sel[rd_bank_q]) begin
            Mul_sel = MUL_SEL_APPLY;
        end
    end

    assign grp_cnt = grp_cnt_q;

endmodule

// File: tb/tb_dtfag_tf_lane_loader.sv
// Directed bench for the twiddle lane loader.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: out_ready driven per scenario.
module tb_dtfag_tf_lane_loader;
    import dtfag_pkg::*;

    localparam int CNT_W = 16;

    logic                     clk;
    logic                     rst_n;
    logic                     flush;
    logic [D_WIDTH-1:0]       tf_data;
    logic                     tf_valid;
    logic                     tf_ready;
    logic                     grp_en;
    logic [LANES*D_WIDTH-1:0] r16_bus;
    logic [1:0]               Mul_sel;
    logic                     out_valid;
    logic                     out_ready;
    logic [CNT_W-1:0]         grp_cnt;

    int checks = 0;
    int errors = 0;

    dtfag_tf_lane_loader #(
        .D_WIDTH (D_WIDTH),
        .LANES   (LANES),
        .CNT_W   (CNT_W)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .tf_data   (tf_data),
        .tf_valid  (tf_valid),
        .tf_ready  (tf_ready),
        .grp_en    (grp_en),
        .r16_bus   (r16_bus),
        .Mul_sel   (Mul_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .grp_cnt   (grp_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word for one cycle; the caller decides whether it should be taken.
    task automatic send(input logic [63:0] dat, input logic en);
        tf_valid = 1'b1;
        tf_data  = dat;
        grp_en   = en;
        tick();
        tf_valid = 1'b0;
    endtask

    task automatic send_group(input int base, input logic first_en);
        for (int k = 0; k < LANES; k++) begin
            send(64'(base + k), (k == 0) ? first_en : 1'b1);
        end
    endtask

    task automatic consume_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    int       ngrp;
    int       gaps;
    logic [CNT_W-1:0] cnt0;

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        tf_data   = '0;
        tf_valid  = 1'b0;
        grp_en    = 1'b0;
        out_ready = 1'b0;

        // 1. Reset values, then asynchronous release mid-cycle.
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_mul_sel",   64'(Mul_sel),   64'd0);
        chk("rst_tf_ready",  64'(tf_ready),  64'd1);
        chk("rst_bus_zero",  64'(|r16_bus),  64'd0);
        rst_n = 1'b1;
        #1;
        tick();
        chk("rel_out_valid", 64'(out_valid), 64'd0);
        chk("rel_tf_ready",  64'(tf_ready),  64'd1);
        chk("rel_grp_cnt",   64'(grp_cnt),   64'd0);

        // 2. Single group of k+1, held by out_ready=0.
        for (int k = 0; k < LANES - 1; k++) send(64'(k + 1), 1'b1);
        chk("g1_not_yet_valid", 64'(out_valid), 64'd0);
        send(64'(LANES), 1'b1);
        chk("g1_valid", 64'(out_valid), 64'd1);
        chk("g1_mul_sel", 64'(Mul_sel), 64'd1);
        for (int k = 0; k < LANES; k++) chk($sformatf("g1_lane%0d", k), lane_of(r16_bus, k), 64'(k + 1));
        tick();
        chk("g1_held_lane0", lane_of(r16_bus, 0), 64'd1);
        chk("g1_held_valid", 64'(out_valid), 64'd1);
        consume_one();
        chk("g1_cnt", 64'(grp_cnt), 64'd1);
        chk("g1_drop", 64'(out_valid), 64'd0);

        // 3. Backpressure: two groups fill both banks, a 33rd word is refused.
        for (int i = 0; i < 2 * LANES; i++) send(64'(i + 1), 1'b1);
        chk("bp_tf_ready_low", 64'(tf_ready), 64'd0);
        send(64'd33, 1'b1);
        chk("bp_still_low", 64'(tf_ready), 64'd0);
        chk("bp_stable_lane0", lane_of(r16_bus, 0), 64'd1);
        chk("bp_stable_lane15", lane_of(r16_bus, LANES - 1), 64'd16);
        consume_one();
        chk("bp_cnt", 64'(grp_cnt), 64'd2);
        chk("bp_ready_back", 64'(tf_ready), 64'd1);
        chk("bp_valid_g2", 64'(out_valid), 64'd1);
        chk("bp_g2_lane0", lane_of(r16_bus, 0), 64'd17);
        chk("bp_g2_lane15", lane_of(r16_bus, LANES - 1), 64'd32);
        consume_one();
        chk("bp_empty", 64'(out_valid), 64'd0);
        // Empty: out_ready must not bump the count.
        consume_one();
        chk("empty_cnt_hold", 64'(grp_cnt), 64'd3);

        // 4. Streaming 64 words with out_ready held high.
        out_ready = 1'b1;
        ngrp = 0;
        gaps = 0;
        cnt0 = grp_cnt;
        for (int i = 0; i < 4 * LANES; i++) begin
            if (!tf_ready) gaps++;
            send(64'(100 + i), 1'b1);
            if (out_valid) begin
                chk($sformatf("st_g%0d_lane0", ngrp), lane_of(r16_bus, 0), 64'(100 + LANES * ngrp));
                chk($sformatf("st_g%0d_lane15", ngrp), lane_of(r16_bus, LANES - 1), 64'(115 + LANES * ngrp));
                ngrp++;
            end
        end
        tick();
        out_ready = 1'b0;
        chk("st_no_gap", 64'(gaps), 64'd0);
        chk("st_groups_seen", 64'(ngrp), 64'd4);
        chk("st_cnt_delta", 64'(grp_cnt - cnt0), 64'd4);
        chk("st_empty", 64'(out_valid), 64'd0);

        // 5. Zero group followed by an applied group.
        send_group(200, 1'b0);
        chk("zg_valid", 64'(out_valid), 64'd1);
        chk("zg_mul_sel", 64'(Mul_sel), 64'd0);
        send_group(300, 1'b1);
        consume_one();
        chk("ag_valid", 64'(out_valid), 64'd1);
        chk("ag_mul_sel", 64'(Mul_sel), 64'd1);
        chk("ag_lane0", lane_of(r16_bus, 0), 64'd300);
        consume_one();
        chk("ag_empty_mul_sel", 64'(Mul_sel), 64'd0);

        // 6a. Flush mid-group discards the partial group and keeps grp_cnt.
        cnt0 = grp_cnt;
        for (int i = 0; i < 7; i++) send(64'(500 + i), 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_cnt_kept", 64'(grp_cnt), 64'(cnt0));
        chk("fl_not_valid", 64'(out_valid), 64'd0);
        for (int k = 0; k < LANES - 1; k++) send(64'(600 + k), 1'b1);
        chk("fl_partial_not_valid", 64'(out_valid), 64'd0);
        send(64'(600 + LANES - 1), 1'b1);
        chk("fl_valid", 64'(out_valid), 64'd1);
        chk("fl_lane0", lane_of(r16_bus, 0), 64'd600);
        chk("fl_lane15", lane_of(r16_bus, LANES - 1), 64'd615);

        // 6b. Reset pulsed mid-group clears everything including grp_cnt.
        for (int i = 0; i < 7; i++) send(64'(650 + i), 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mr_out_valid", 64'(out_valid), 64'd0);
        chk("mr_bus_zero", 64'(|r16_bus), 64'd0);
        #2;
        rst_n = 1'b1;
        tick();
        chk("mr_grp_cnt", 64'(grp_cnt), 64'd0);
        chk("mr_tf_ready", 64'(tf_ready), 64'd1);
        send_group(700, 1'b1);
        chk("mr_valid", 64'(out_valid), 64'd1);
        chk("mr_lane0", lane_of(r16_bus, 0), 64'd700);
        chk("mr_lane15", lane_of(r16_bus, LANES - 1), 64'd715);
        consume_one();
        chk("mr_cnt_one", 64'(grp_cnt), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
